sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words; power of two, 4..1024.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port write_en  input  1  write request.
REQ-008 SHALL have port read_en  input  1  read request.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port data_out  output  WIDTH  read data.
REQ-011 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-014 SHALL accept a write on a rising edge when write_en=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-015 SHALL accept a read on a rising edge when read_en=1 and empty=0.
REQ-016 SHALL, on write_en=1 with full=1 and no accepted read, drop the write, leave memory/count unchanged, and pulse overflow for one cycle.
REQ-017 SHALL, on read_en=1 with empty=1, ignore the read (including same-cycle write to empty), leave data_out unchanged, and pulse underflow for one cycle.
REQ-018 SHALL, on simultaneous accepted read and write, keep count unchanged and advance both pointers.
REQ-019 SHALL use log2(DEPTH)-bit read/write pointers wrapping DEPTH-1 -> 0 with no gap.
REQ-020 SHALL derive all flags and count from registered state only: full = (count==DEPTH), empty = (count==0); flags valid the cycle after the edge that changes count.
REQ-021 SHALL, in standard mode, register data_out from the head word on the edge of an accepted read (1-cycle read latency); data_out holds between reads.
REQ-022 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-023 SHALL keep overflow and underflow low in every cycle not meeting REQ-016/REQ-017.

Reset
REQ-024 SHALL, while rst=0, force count=0, pointers=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0, asynchronously.
REQ-025 SHALL not clear storage memory on reset; contents are unobservable until rewritten.
REQ-026 SHALL, on reset asserted mid-operation, discard all stored words; first read after reset release returns the first word written after release.
REQ-027 SHALL ignore write_en/read_en on the first rising edge where rst is already released only if rst deasserts within setup of that edge (synchroniser-free; deassert synchronous to clk is the integrator's responsibility).

Configuration
REQ-028 SHALL support macro SYNC_FIFO_FWFT_EN selecting first-word-fall-through mode.
REQ-029 SHALL, with SYNC_FIFO_FWFT_EN defined, drive data_out combinationally from the head word whenever empty=0 (zero read latency), read_en acting as pop/acknowledge; data_out=0 when empty=1.
REQ-030 SHALL, without SYNC_FIFO_FWFT_EN, behave per REQ-021; all other requirements are identical in both modes.

Verification (WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
REQ-031 SHALL cover: reset, write 0x01..0x10 (16 words) -> full=1 after 16th edge, almost_full=1 from count=14, count=16; 17th write 0xAA -> overflow pulse 1 cycle, count stays 16.
REQ-032 SHALL cover: from full, read 16 words -> data_out 0x01..0x10 in order (standard: one cycle after each read edge), empty=1 at end; extra read -> underflow pulse, data_out holds 0x10.
REQ-033 SHALL cover: wrap-around: write 10, read 10, write 12 (0x20..0x2B), read 12 -> order 0x20..0x2B exact, count returns 0.
REQ-034 SHALL cover: simultaneous read+write at count=16 -> no overflow, count stays 16, written word appears 16 reads later; at count=0 -> underflow pulse, count becomes 1.
REQ-035 SHALL cover: rst=0 asserted between edges at count=7 -> count=0, empty=1, data_out=0 immediately (before next clk edge); subsequent write 0x55 then read returns 0x55.
REQ-036 SHALL cover: with SYNC_FIFO_FWFT_EN, write 0x3C into empty FIFO -> data_out=0x3C the cycle empty deasserts, before any read_en; read_en pops and empty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parameterised FIFO with status flags and error pulses
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read data.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_en,
   input  logic                     read_en,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             ovf_q;
   logic             udf_q;
   logic             rd_acc;
   logic             wr_acc;

   assign full         = (cnt_q == DEPTH_C);
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= AF_C);
   assign almost_empty = (cnt_q <= AE_C);
   assign count        = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // A pop frees a slot in the same cycle, so a write at full is accepted alongside it.
   assign rd_acc = read_en && !empty;
   assign wr_acc = write_en && (!full || rd_acc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         ovf_q <= write_en && full && !rd_acc;
         udf_q <= read_en && empty;
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_acc && !rd_acc)
            cnt_q <= cnt_q + CW'(1);
         else if (rd_acc && !wr_acc)
            cnt_q <= cnt_q - CW'(1);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= data_in;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : mem[rd_ptr];
`else
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         data_q <= '0;
      else if (rd_acc)
         data_q <= mem[rd_ptr];
   end

   assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16)
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       write_en = 1'b0;
   logic       read_en = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty, almost_full, almost_empty;
   logic [4:0] count;
   logic       overflow, underflow;
   int         n_cmp = 0;
   int         n_fail = 0;

   sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
      .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic we, input logic re, input logic [7:0] d);
      write_en = we;
      read_en  = re;
      data_in  = d;
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   // Returns the word delivered by one pop in whichever read mode is built.
   task automatic pop(output logic [7:0] d);
`ifdef SYNC_FIFO_FWFT_EN
      d = data_out;
      cycle(1'b0, 1'b1, 8'h00);
`else
      cycle(1'b0, 1'b1, 8'h00);
      d = data_out;
`endif
   endtask

   task automatic test_reset;
      #2;
      n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", almost_empty); end
      n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b%b want 00", full, almost_full); end
      n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
      n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", data_out); end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_fill;
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0, 8'(i));
         n_cmp++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
         n_cmp++; if (almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 14)); end
         n_cmp++; if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 16)); end
         n_cmp++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i <= 2)); end
      end
      cycle(1'b1, 1'b0, 8'hAA);
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", overflow); end
      n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
      cycle(1'b0, 1'b0, 8'h00);
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_drain;
      logic [7:0] d;
      for (int i = 1; i <= 16; i++) begin
         pop(d);
         n_cmp++; if (d !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, d, 8'(i)); end
         n_cmp++; if (count !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 16 - i); end
         n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf[%0d] got %b want 0", i, underflow); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
      cycle(1'b0, 1'b1, 8'h00);
      n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got %b want 1", underflow); end
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL udf_dout got %h want 00", data_out); end
`else
      n_cmp++; if (data_out !== 8'h10) begin n_fail++; $display("FAIL udf_dout got %h want 10", data_out); end
`endif
      cycle(1'b0, 1'b0, 8'h00);
      n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %b want 0", underflow); end
   endtask

   task automatic test_wrap;
      logic [7:0] d;
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
      for (int i = 0; i < 10; i++) begin
         pop(d);
         n_cmp++; if (d !== 8'(8'h60 + i)) begin n_fail++; $display("FAIL wrap_pre[%0d] got %h want %h", i, d, 8'(8'h60 + i)); end
      end
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
      n_cmp++; if (count !== 5'd12) begin n_fail++; $display("FAIL wrap_count12 got %0d want 12", count); end
      for (int i = 0; i < 12; i++) begin
         pop(d);
         n_cmp++; if (d !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, d, 8'(8'h20 + i)); end
      end
      n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_count0 got %0d want 0", count); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
`ifdef SYNC_FIFO_FWFT_EN
      d = data_out;
      cycle(1'b1, 1'b1, 8'hC5);
`else
      cycle(1'b1, 1'b1, 8'hC5);
      d = data_out;
`endif
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rw_full_ovf got %b want 0", overflow); end
      n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL rw_full_count got %0d want 16", count); end
      n_cmp++; if (d !== 8'h80) begin n_fail++; $display("FAIL rw_full_data got %h want 80", d); end
      for (int i = 1; i < 16; i++) begin
         pop(d);
         n_cmp++; if (d !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL rw_drain[%0d] got %h want %h", i, d, 8'(8'h80 + i)); end
      end
      pop(d);
      n_cmp++; if (d !== 8'hC5) begin n_fail++; $display("FAIL rw_late_word got %h want c5", d); end
      cycle(1'b1, 1'b1, 8'h77);
      n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL rw_empty_udf got %b want 1", underflow); end
      n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL rw_empty_count got %0d want 1", count); end
      pop(d);
      n_cmp++; if (d !== 8'h77) begin n_fail++; $display("FAIL rw_empty_data got %h want 77", d); end
   endtask

   task automatic test_mid_reset;
      logic [7:0] d;
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
      pop(d);
      n_cmp++; if (count !== 5'd7) begin n_fail++; $display("FAIL mrst_pre_count got %0d want 7", count); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL mrst_count got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mrst_empty got %b want 1", empty); end
      n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mrst_dout got %h want 00", data_out); end
      #1;
      rst = 1'b1;
      cycle(1'b1, 1'b0, 8'h55);
      pop(d);
      n_cmp++; if (d !== 8'h55) begin n_fail++; $display("FAIL mrst_first got %h want 55", d); end
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft;
      cycle(1'b1, 1'b0, 8'h3C);
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fwft_empty got %b want 0", empty); end
      n_cmp++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL fwft_dout got %h want 3c", data_out); end
      cycle(1'b0, 1'b1, 8'h00);
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty got %b want 1", empty); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
